// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
//
// Packs a 32-bit immediate plus register/opcode fields into RV32I instruction
// words (I, S, B formats). It also expands a load-immediate (LI) request into
// a LUI/ADDI pair, or into a single word when that is enough. Immediates that
// do not fit the selected format raise out_err, but the word is still emitted.
// There is a valid/ready stream on each side, and the output is registered.
//
// Parameters:
//   OPT_SHORT  1: an LI whose upper part is zero becomes a single ADDI rd,x0,lo
//              0: an LI always starts with a LUI
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready at the edge
//   in_mode    format select: 00 I, 01 S, 11 B, 10 LI (same as opcode[6:5])
//   in_opcode  opcode field (I/S/B)
//   in_funct3  funct3 field (I/S/B)
//   in_rd      destination register (I, LI)
//   in_rs1     source register 1 (I/S/B)
//   in_rs2     source register 2 (S/B)
//   in_imm     signed immediate, or the full LI value
//   out_valid  output word valid
//   out_ready  downstream takes the word when out_valid && out_ready
//   out_instr  encoded instruction word
//   out_last   final word of the current request
//   out_err    immediate out of range or misaligned
// ---------------------------------------------------------------------------
module imm_encoder #(
  parameter bit OPT_SHORT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_mode,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  localparam logic [1:0] MODE_I  = 2'b00;
  localparam logic [1:0] MODE_S  = 2'b01;
  localparam logic [1:0] MODE_LI = 2'b10;
  localparam logic [1:0] MODE_B  = 2'b11;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  // IDLE: nothing held. ONE: holding the final word of a request.
  // FIRST: holding a LUI while the follow-up ADDI waits in pend_q.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ONE   = 2'b01,
    ST_FIRST = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_q,  pend_d;
  logic        err_q,   err_d;

  // Encoder results for the request currently on the input port.
  logic [31:0] enc_first;
  logic [31:0] enc_second;
  logic        enc_two;
  logic        enc_err;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic        accept;

  // A 12-bit signed immediate fits when bits 31..11 are all copies of the sign.
  function automatic logic fits_imm12(input logic [31:0] imm);
    return (imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF);
  endfunction

  // A 13-bit signed branch offset fits when bits 31..12 are all the same.
  function automatic logic fits_imm13(input logic [31:0] imm);
    return (imm[31:12] == 20'h00000) || (imm[31:12] == 20'hFFFFF);
  endfunction

  function automatic logic [31:0] pack_i(input logic [31:0] imm,
                                         input logic [4:0]  rs1,
                                         input logic [2:0]  funct3,
                                         input logic [4:0]  rd,
                                         input logic [6:0]  opcode);
    return {imm[11:0], rs1, funct3, rd, opcode};
  endfunction

  function automatic logic [31:0] pack_s(input logic [31:0] imm,
                                         input logic [4:0]  rs2,
                                         input logic [4:0]  rs1,
                                         input logic [2:0]  funct3,
                                         input logic [6:0]  opcode);
    return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
  endfunction

  function automatic logic [31:0] pack_b(input logic [31:0] imm,
                                         input logic [4:0]  rs2,
                                         input logic [4:0]  rs1,
                                         input logic [2:0]  funct3,
                                         input logic [6:0]  opcode);
    return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
  endfunction

  // Encode the incoming request. For LI the upper part is rounded up when
  // lo is negative, because the ADDI sign-extends lo. The 20-bit sum wraps,
  // so values such as 0xFFFFF800 end up with hi == 0.
  always_comb begin
    enc_first  = '0;
    enc_second = '0;
    enc_two    = 1'b0;
    enc_err    = 1'b0;
    li_hi      = in_imm[31:12] + {19'd0, in_imm[11]};
    li_lo      = in_imm[11:0];

    case (in_mode)
      MODE_I: begin
        enc_first = pack_i(in_imm, in_rs1, in_funct3, in_rd, in_opcode);
        enc_err   = !fits_imm12(in_imm);
      end
      MODE_S: begin
        enc_first = pack_s(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
        enc_err   = !fits_imm12(in_imm);
      end
      MODE_B: begin
        enc_first = pack_b(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
        enc_err   = in_imm[0] || !fits_imm13(in_imm);
      end
      MODE_LI: begin
        if (OPT_SHORT && (li_hi == 20'd0)) begin
          enc_first = {li_lo, 5'd0, 3'b000, in_rd, OP_ADDI};
        end else begin
          enc_first  = {li_hi, in_rd, OP_LUI};
          enc_second = {li_lo, in_rd, 3'b000, in_rd, OP_ADDI};
          enc_two    = (li_lo != 12'd0);
        end
      end
      default: begin
        enc_first = '0;
      end
    endcase
  end

  // State and data registers; reset drops any held word and pending ADDI.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. An accept can happen in ONE in the same cycle the held
  // word leaves, so the new word replaces it with no bubble.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pend_d  = pend_q;
    err_d   = err_q;

    if (accept) begin
      state_d = enc_two ? ST_FIRST : ST_ONE;
      instr_d = enc_first;
      pend_d  = enc_second;
      err_d   = enc_err;
    end else begin
      case (state_q)
        ST_FIRST: begin
          if (out_ready) begin
            state_d = ST_ONE;
            instr_d = pend_q;
            err_d   = 1'b0;
          end
        end
        ST_ONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Outputs. in_ready looks at out_ready combinationally, so a held final
  // word and a new request can trade places on one edge.
  always_comb begin
    in_ready  = !rst && ((state_q == ST_IDLE) ||
                         ((state_q == ST_ONE) && out_ready));
    accept    = in_valid && in_ready;
    out_valid = (state_q != ST_IDLE);
    out_last  = (state_q == ST_ONE);
    out_instr = instr_q;
    out_err   = err_q;
  end

endmodule

// File: tb/tb_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_encoder
//
// Self-checking bench for imm_encoder (OPT_SHORT = 1). A table of requests
// with hand-derived expected words is driven in a loop. Each expected word
// goes onto a scoreboard queue when its request is accepted. A monitor pops
// the queue whenever the DUT hands a word downstream. Hand-written sequences
// cover reset, backpressure during a two-word LI, back-to-back streaming,
// and reset in the middle of an LI.
// ---------------------------------------------------------------------------
module tb_imm_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  typedef struct {
    logic [1:0]  mode;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  vec_t stream[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  imm_encoder #(.OPT_SHORT(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, used to show that streamed requests go in on consecutive edges.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Build one table entry.
  function automatic vec_t mkVec(input logic [1:0] mode, input logic [6:0] opcode,
                                 input logic [2:0] funct3, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input int nw,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic err);
    vec_t v;
    v.mode = mode; v.opcode = opcode; v.funct3 = funct3; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.nw = nw;
    v.w0 = w0; v.w1 = w1; v.err = err;
    return v;
  endfunction

  // Compare a 32-bit value with its expected value and record the result.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare a single-bit value with its expected value and record the result.
  task automatic checkFlag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one request, starting just after a rising edge. Wait (bounded)
  // for it to be accepted and push its expected words onto the scoreboard.
  // Return just after the accepting edge with in_valid still high, so the
  // caller can send the next request back to back.
  task automatic applyStimulus(input vec_t v, output int acc_cycle);
    bit done;
    done      = 1'b0;
    acc_cycle = -1;
    in_mode   = v.mode;
    in_opcode = v.opcode;
    in_funct3 = v.funct3;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_imm    = v.imm;
    in_valid  = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        done      = 1'b1;
        acc_cycle = cycle_cnt;
        if (v.nw == 2) begin
          sb.push_back('{instr: v.w0, last: 1'b0, err: 1'b0});
          sb.push_back('{instr: v.w1, last: 1'b1, err: 1'b0});
        end else begin
          sb.push_back('{instr: v.w0, last: 1'b1, err: v.err});
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      in_valid = 1'b0;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  // Wait (bounded) until the monitor has consumed every expected word.
  task automatic waitDrain(input string name);
    for (int t = 0; t < 40 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    checkOutput(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: on every falling edge where a word is handed downstream, pop
  // the oldest expected word and compare word, last and err.
  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%08h expected no word", out_instr);
        end else begin
          e = sb.pop_front();
          checkOutput("out_instr", out_instr, e.instr);
          checkFlag("out_last", out_last, e.last);
          checkFlag("out_err", out_err, e.err);
        end
      end
    end
  endtask

  // Main sequence: reset, table, then the hand-written corner cases.
  initial begin
    int acc;
    int acc_first;
    vec_t li2;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = '0;
    in_opcode = '0;
    in_funct3 = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm    = '0;
    out_ready = 1'b0;

    fork
      monitorLoop();
    join_none

    // Each expected word below was worked out by hand from the field layouts.
    vecs.push_back(mkVec(2'b00, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF08293, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b00, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'd2048,     1, 32'h80008293, 32'h0, 1'b1));
    vecs.push_back(mkVec(2'b00, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'd2047,     1, 32'h7FF08293, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b00, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'hFFFFF800, 1, 32'h80008293, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b00, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'hFFFFF7FF, 1, 32'h7FF08293, 32'h0, 1'b1));
    vecs.push_back(mkVec(2'b01, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8,        1, 32'h0020A423, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b01, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFF, 1, 32'hFE20AFA3, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b11, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1, 32'hFE208EE3, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b11, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3,        1, 32'h00208163, 32'h0, 1'b1));
    vecs.push_back(mkVec(2'b11, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4096,     1, 32'h80208063, 32'h0, 1'b1));
    vecs.push_back(mkVec(2'b11, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFF000, 1, 32'h80208063, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b10, 7'h7F, 3'd7, 5'd10, 5'd31, 5'd31, 32'h12345FFF, 2, 32'h12346537, 32'hFFF50513, 1'b0));
    vecs.push_back(mkVec(2'b10, 7'h7F, 3'd7, 5'd1, 5'd31, 5'd31, 32'h000007FF, 1, 32'h7FF00093, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b10, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00001000,   1, 32'h000010B7, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b10, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800,   1, 32'h80000093, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b10, 7'h55, 3'd5, 5'd3, 5'd7, 5'd9, 32'h00000000,   1, 32'h00000193, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b10, 7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 32'h80000000,   1, 32'h80000037, 32'h0, 1'b0));
    vecs.push_back(mkVec(2'b10, 7'h00, 3'd0, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF,   1, 32'hFFF00113, 32'h0, 1'b0));

    stream.push_back(mkVec(2'b00, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'd0,          1, 32'h00008293, 32'h0, 1'b0));
    stream.push_back(mkVec(2'b00, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'd1,          1, 32'h00108293, 32'h0, 1'b0));
    stream.push_back(mkVec(2'b00, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'hFFFFFFFE,   1, 32'hFFE08293, 32'h0, 1'b0));
    stream.push_back(mkVec(2'b00, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'd100,        1, 32'h06408293, 32'h0, 1'b0));

    li2 = vecs[11];

    // Reset state, both while reset is held and on the cycle after release.
    repeat (2) @(posedge clk);
    #1;
    checkFlag("rst_in_ready", in_ready, 1'b0);
    checkFlag("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    checkFlag("rst_out_last", out_last, 1'b0);
    checkFlag("rst_out_err", out_err, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkFlag("post_rst_out_valid", out_valid, 1'b0);
    checkFlag("post_rst_in_ready", in_ready, 1'b1);

    // Table-driven vectors, one request at a time, downstream always ready.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], acc);
      in_valid = 1'b0;
      waitDrain("table_drain");
    end

    // Backpressure in the middle of a two-word LI. The LUI and its flags must
    // hold, and no new request may be taken while in FIRST.
    out_ready = 1'b0;
    applyStimulus(li2, acc);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkFlag("bp_out_valid", out_valid, 1'b1);
      checkOutput("bp_out_instr", out_instr, 32'h12346537);
      checkFlag("bp_out_last", out_last, 1'b0);
      checkFlag("bp_out_err", out_err, 1'b0);
      checkFlag("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkFlag("first_in_ready", in_ready, 1'b0);
    waitDrain("bp_drain");

    // Four back-to-back I-type requests: each must be taken on a consecutive
    // edge, and a word must be valid after every one of them.
    acc_first = 0;
    foreach (stream[i]) begin
      applyStimulus(stream[i], acc);
      if (i == 0) acc_first = acc;
      checkFlag("stream_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    checkOutput("stream_span", 32'(acc - acc_first), 32'd3);
    waitDrain("stream_drain");

    // Reset while in FIRST: the held LUI and the pending ADDI are dropped.
    out_ready = 1'b0;
    applyStimulus(li2, acc);
    in_valid = 1'b0;
    checkFlag("pre_rst_out_last", out_last, 1'b0);
    rst = 1'b1;
    #1;
    checkFlag("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    checkFlag("mid_rst_out_valid", out_valid, 1'b0);
    checkOutput("mid_rst_out_instr", out_instr, 32'h0);
    sb.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkFlag("after_rst_no_addi", out_valid, 1'b0);
    end

    // The encoder must still work normally after that reset.
    @(posedge clk);
    #1;
    applyStimulus(vecs[0], acc);
    in_valid = 1'b0;
    waitDrain("recover_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Packs a 32-bit immediate plus register/opcode fields into RV32I instruction words; the inverse of the core's immediate extraction. It encodes I-, S- and B-format instructions and expands a load-immediate (LI) into a LUI/ADDI sequence. It reports immediates that do not fit the selected format. It sits in front of instruction memory in the test/boot loader path, with a valid/ready stream on each side and a registered output.

## Interface
- `OPT_SHORT`, default 1: when 1, an LI whose upper part is zero emits a single ADDI; when 0, LI always emits LUI first.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at the clock edge.
- `in_mode`  in  2  format select, same coding as opcode[6:5]: 00 I, 01 S, 11 B, 10 LI.
- `in_opcode`  in  7  opcode field (I/S/B only).
- `in_funct3`  in  3  funct3 field (I/S/B only).
- `in_rd`  in  5  destination register (I, LI).
- `in_rs1`  in  5  source register 1 (I/S/B).
- `in_rs2`  in  5  source register 2 (S/B).
- `in_imm`  in  32  signed immediate / LI value.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word at the edge when `out_valid && out_ready`.
- `out_instr`  out  32  encoded instruction word.
- `out_last`  out  1  final word of the current request.
- `out_err`  out  1  immediate out of range or misaligned; word is still emitted.

## Operation
- **I format:** `{imm[11:0], rs1, funct3, rd, opcode}`. `err` is set when `imm[31:11]` is not all-equal, i.e. the value is outside -2048..2047.
- **S format:** `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`. `err` uses the same range rule as I.
- **B format:** `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`. `err` is set if `imm[0]` is 1 or `imm[31:12]` is not all-equal.
- **LI format:**
  - Split: `hi = imm[31:12] + imm[11]` (20-bit, wraps modulo 2^20); `lo = imm[11:0]`.
  - Word list, in order:
    - `OPT_SHORT=1` and `hi==0`: ADDI rd,x0,lo = `{lo, 5'd0, 3'b000, rd, 7'b0010011}`.
    - Otherwise: LUI rd,hi = `{hi, rd, 7'b0110111}`, then, only if `lo!=0`, ADDI rd,rd,lo = `{lo, rd, 3'b000, rd, 7'b0010011}`.
  - `in_opcode`, `in_funct3`, `in_rs1` and `in_rs2` are ignored. `err` is 0. `rd=0` is encoded normally.
- **State machine** (three states):
  - IDLE: no word held.
  - ONE: holding the final word.
  - FIRST: holding the LUI while an ADDI is pending. The pending ADDI word is latched at accept.
  - Accept from IDLE, or from ONE when the held word is consumed that cycle. A two-word LI goes to FIRST; everything else goes to ONE.
  - FIRST with `out_ready`: load the ADDI, go to ONE.
  - ONE with `out_ready` and no accept: go to IDLE.
- `in_ready = !rst && (state==IDLE || (state==ONE && out_ready))`. This is combinational from state and `out_ready`.
- `out_valid = (state != IDLE)`.
- `out_last` is 1 in ONE and 0 in FIRST.

## Timing
- **Reset values:** while `rst` is high and on the following cycle, `out_valid=0`, `out_instr=0`, `out_last=0`, `out_err=0`, `state=IDLE`. `in_ready=0` while `rst` is high.
- **Reset mid-operation:** reset in FIRST or ONE discards the held word and any pending ADDI; neither is ever emitted.
- **Latency:** a request accepted at edge k drives `out_valid` with its first word after edge k (visible in cycle k+1).
- **Throughput:** single-word requests run at one per cycle with `out_ready` held high. A two-word LI occupies two output cycles, and `in_ready=0` while in FIRST.
- **Backpressure:** `out_instr`, `out_last` and `out_err` are held stable while `out_valid && !out_ready`.
- **Simultaneous events:** consume and accept in the same ONE cycle replaces the word with no bubble.

## Test plan
- **I format:** mode 00, opcode 0x13, funct3 0, rd 5, rs1 1, imm -1 -> `out_instr` 0xFFF08293, last 1, err 0. The same with imm 2048 -> err 1.
- **S and B formats:**
  - S: opcode 0x23, funct3 2, rs1 1, rs2 2, imm 8 -> 0x0020A423.
  - B: opcode 0x63, funct3 0, rs1 1, rs2 2, imm -4 -> 0xFE208EE3, err 0.
  - B with imm 3 -> err 1.
- **Two-word LI:** LI 0x12345FFF, rd 10 -> 0x12346537 (last 0), then 0xFFF50513 (last 1). `in_ready=0` between the two words.
- **Short and LUI-only LI:** with `OPT_SHORT=1`:
  - LI 0x7FF, rd 1 -> single 0x7FF00093.
  - LI 0x1000, rd 1 -> single LUI 0x000010B7.
  - LI 0xFFFFF800, rd 1 -> single ADDI 0x80000093 (hi wraps to 0).
- **Backpressure and streaming:** hold `out_ready=0` for 3 cycles mid-LI -> word and flags stable, no acceptance. Then stream 4 I-type requests with `out_ready=1` -> 4 consecutive valid words with no bubbles.
- **Reset mid-LI:** assert `rst` in FIRST -> `out_valid=0` the next cycle, and the ADDI never appears after reset release.
